rom_seq: RTL and testbench

Parametrised synchronous ROM with a registered read path, valid/ready handshakes on both sides, and a burst sequencer. One request of start address plus length streams consecutive words, with address wrap-around at DEPTH.
It replaces ad-hoc combinational case-ROMs wherever table data must be fetched under flow control, such as coefficient or pattern tables feeding datapath blocks.
Contents come from a package function, so each instance differs only by parameters.

---
 rtl/rom_seq_pkg.sv | 28 ++
 rtl/rom_seq_array.sv | 57 +++++
 rtl/rom_seq.sv | 199 +++++++++++++++++++
 tb/tb_rom_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared definitions for the rom_seq burst-read ROM.
//   - default geometry (word width, address width, table depth)
//   - sequencer state type
//   - rom_word(): constant table contents, evaluated at elaboration
package rom_seq_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int ADDR_W_DEF = 3;
   localparam int DEPTH_DEF  = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   // Table contents; addresses not listed read as zero.
   function automatic logic [31:0] rom_word(input int unsigned addr);
      case (addr)
         32'd0:   rom_word = 32'h0000_0009;
         32'd1:   rom_word = 32'h0000_000B;
         32'd2:   rom_word = 32'h0000_0002;
         32'd3:   rom_word = 32'h0000_0003;
         32'd4:   rom_word = 32'h0000_000E;
         default: rom_word = 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/rom_seq_array.sv
// rom_sync_array: synchronous-read ROM with a load enable.
//   i_clk, i_rst : clock, synchronous active-high reset (clears the read register)
//   i_en         : load the read register from i_addr this cycle, otherwise hold
//   i_addr       : read address
//   o_dat        : registered word (0 for addresses >= DEPTH)
//   o_err        : registered flag, address was >= DEPTH
module rom_sync_array
   import rom_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] o_dat,
   output logic              o_err
);

   localparam int              N_ENT   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   // Table spans the whole address space so any address indexes safely;
   // entries at or beyond DEPTH are tied to zero.
   logic [DATA_W-1:0] table_s [N_ENT];

   for (genvar g = 0; g < N_ENT; g++) begin : g_tbl
      if (g < DEPTH) begin : g_used
         assign table_s[g] = DATA_W'(rom_word(g));
      end else begin : g_unused
         assign table_s[g] = '0;
      end
   end

   logic [DATA_W-1:0] dat_r;
   logic              err_r;

   // Read register: loads only on an issued read so the word holds otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dat_r <= '0;
         err_r <= 1'b0;
      end else if (i_en) begin
         dat_r <= table_s[i_addr];
         err_r <= ({1'b0, i_addr} >= DEPTH_C);
      end else begin
         dat_r <= dat_r;
         err_r <= err_r;
      end
   end

   assign o_dat = dat_r;
   assign o_err = err_r;

endmodule

// File: rtl/rom_seq.sv
// rom_seq: burst sequencer over a synchronous ROM with valid/ready on both sides.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req_vld / o_req_rdy : burst request handshake; i_addr start, i_len beats-1
//   o_dat_vld / i_dat_rdy : output beat handshake
//   o_dat, o_last, o_err  : beat word, final-beat flag, out-of-range flag
//   o_busy                : burst running or beats still in the pipeline
// The first read is issued in the acceptance cycle itself, so the first beat
// appears 1+OUT_REG cycles later. Any output stall freezes the whole pipe.
module rom_seq
   import rom_seq_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int OUT_REG = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_vld,
   output logic              o_req_rdy,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ADDR_W-1:0] i_len,
   output logic              o_dat_vld,
   input  logic              i_dat_rdy,
   output logic [DATA_W-1:0] o_dat,
   output logic              o_last,
   output logic              o_err,
   output logic              o_busy
);

   localparam logic [ADDR_W:0] LAST_C = (ADDR_W + 1)'(DEPTH) - (ADDR_W + 1)'(1);

   // Successor address: wrap to 0 at DEPTH-1, and also from any out-of-range address.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if ({1'b0, a} >= LAST_C) begin
         next_addr = '0;
      end else begin
         next_addr = a + ADDR_W'(1);
      end
   endfunction

   seq_state_e        state_r, state_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
   logic              rdy_r, busy_r;
   logic              stall_s, issue_s, issue_last_s;
   logic [ADDR_W-1:0] issue_addr_s;
   logic              s1_vld_r, s1_vld_nxt_s, s1_last_r;
   logic [DATA_W-1:0] s1_dat_s;
   logic              s1_err_s;
   logic              out_vld_s, out_vld_nxt_s, out_last_s, out_err_s;
   logic [DATA_W-1:0] out_dat_s;

   assign stall_s      = out_vld_s & ~i_dat_rdy;
   assign s1_vld_nxt_s = stall_s ? s1_vld_r : issue_s;

   // Issue decode: in IDLE a request issues straight from the inputs unless the
   // output is stalled, in which case it is parked in addr_r/cnt_r for RUN.
   always_comb begin
      state_nxt_s  = state_r;
      addr_nxt_s   = addr_r;
      cnt_nxt_s    = cnt_r;
      issue_s      = 1'b0;
      issue_addr_s = addr_r;
      issue_last_s = (cnt_r == '0);
      case (state_r)
         ST_IDLE: begin
            issue_addr_s = i_addr;
            issue_last_s = (i_len == '0);
            if (rdy_r && i_req_vld) begin
               if (stall_s) begin
                  state_nxt_s = ST_RUN;
                  addr_nxt_s  = i_addr;
                  cnt_nxt_s   = i_len;
               end else begin
                  issue_s = 1'b1;
                  if (i_len != '0) begin
                     state_nxt_s = ST_RUN;
                     addr_nxt_s  = next_addr(i_addr);
                     cnt_nxt_s   = i_len - ADDR_W'(1);
                  end else begin
                     state_nxt_s = ST_IDLE;
                  end
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!stall_s) begin
               issue_s = 1'b1;
               if (cnt_r == '0) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  addr_nxt_s = next_addr(addr_r);
                  cnt_nxt_s  = cnt_r - ADDR_W'(1);
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, burst address/counter and the registered ready/busy flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         addr_r  <= '0;
         cnt_r   <= '0;
         rdy_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         addr_r  <= addr_nxt_s;
         cnt_r   <= cnt_nxt_s;
         rdy_r   <= (state_nxt_s == ST_IDLE);
         busy_r  <= (state_nxt_s == ST_RUN) | s1_vld_nxt_s | out_vld_nxt_s;
      end
   end

   // Read-stage control bits travelling alongside the ROM word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_vld_r  <= 1'b0;
         s1_last_r <= 1'b0;
      end else begin
         s1_vld_r  <= s1_vld_nxt_s;
         s1_last_r <= issue_s ? issue_last_s : s1_last_r;
      end
   end

   rom_sync_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (issue_s),
      .i_addr (issue_addr_s),
      .o_dat  (s1_dat_s),
      .o_err  (s1_err_s)
   );

   if (OUT_REG != 0) begin : g_out_reg
      logic              s2_vld_r, s2_last_r, s2_err_r;
      logic [DATA_W-1:0] s2_dat_r;

      // Extra output stage; advances only when not stalled, data loads only on a valid beat.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            s2_vld_r  <= 1'b0;
            s2_last_r <= 1'b0;
            s2_err_r  <= 1'b0;
            s2_dat_r  <= '0;
         end else if (!stall_s) begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
               s2_last_r <= s1_last_r;
               s2_err_r  <= s1_err_s;
               s2_dat_r  <= s1_dat_s;
            end else begin
               s2_last_r <= s2_last_r;
               s2_err_r  <= s2_err_r;
               s2_dat_r  <= s2_dat_r;
            end
         end else begin
            s2_vld_r  <= s2_vld_r;
            s2_last_r <= s2_last_r;
            s2_err_r  <= s2_err_r;
            s2_dat_r  <= s2_dat_r;
         end
      end

      assign out_vld_s     = s2_vld_r;
      assign out_last_s    = s2_last_r;
      assign out_err_s     = s2_err_r;
      assign out_dat_s     = s2_dat_r;
      assign out_vld_nxt_s = stall_s ? s2_vld_r : s1_vld_r;
   end else begin : g_no_out_reg
      assign out_vld_s     = s1_vld_r;
      assign out_last_s    = s1_last_r;
      assign out_err_s     = s1_err_s;
      assign out_dat_s     = s1_dat_s;
      assign out_vld_nxt_s = s1_vld_nxt_s;
   end

   assign o_req_rdy = rdy_r;
   assign o_busy    = busy_r;
   assign o_dat_vld = out_vld_s;
   assign o_dat     = out_dat_s;
   assign o_last    = out_last_s;
   assign o_err     = out_err_s;

endmodule

// File: tb/tb_rom_seq.sv
// tb_rom_seq: two rom_seq instances (DEPTH=8/OUT_REG=0 and DEPTH=5/OUT_REG=1)
// driven one at a time. A burst model expands every accepted request into the
// list of beats it must produce; each consumed beat is compared in order.
module tb_rom_seq;

   typedef struct packed {
      logic [31:0] acc;
      logic        first;
      logic        err;
      logic        last;
      logic [3:0]  dat;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst     [2];
   logic       req_vld [2];
   logic [2:0] addr    [2];
   logic [2:0] len     [2];
   logic       dat_rdy [2];
   logic       req_rdy [2];
   logic       dat_vld [2];
   logic [3:0] dat     [2];
   logic       last    [2];
   logic       err     [2];
   logic       busy    [2];

   logic [3:0] tbl [8] = '{4'h9, 4'hB, 4'h2, 4'h3, 4'hE, 4'h0, 4'h0, 4'h0};

   beat_t q0[$];
   beat_t q1[$];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;
   logic acc_now = 1'b0;
   logic lat_on  = 1'b0;
   logic hold_pend = 1'b0;
   logic [3:0] h_dat;
   logic h_last, h_err;

   always #5 clk = ~clk;

   rom_seq #(.DATA_W(4), .ADDR_W(3), .DEPTH(8), .OUT_REG(0)) dut0 (
      .i_clk(clk), .i_rst(rst[0]), .i_req_vld(req_vld[0]), .o_req_rdy(req_rdy[0]),
      .i_addr(addr[0]), .i_len(len[0]), .o_dat_vld(dat_vld[0]), .i_dat_rdy(dat_rdy[0]),
      .o_dat(dat[0]), .o_last(last[0]), .o_err(err[0]), .o_busy(busy[0]));

   rom_seq #(.DATA_W(4), .ADDR_W(3), .DEPTH(5), .OUT_REG(1)) dut1 (
      .i_clk(clk), .i_rst(rst[1]), .i_req_vld(req_vld[1]), .o_req_rdy(req_rdy[1]),
      .i_addr(addr[1]), .i_len(len[1]), .o_dat_vld(dat_vld[1]), .i_dat_rdy(dat_rdy[1]),
      .o_dat(dat[1]), .o_last(last[1]), .o_err(err[1]), .o_busy(busy[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qclear(input int k);
      if (k == 0) q0.delete(); else q1.delete();
   endtask

   // Expand a request into its beats: consecutive addresses, wrapping to 0
   // after DEPTH-1 or from any out-of-range address.
   task automatic push_burst(input int k, input int a0, input int l);
      int    depth = (k == 0) ? 8 : 5;
      int    a = a0;
      beat_t e;
      for (int j = 0; j <= l; j++) begin
         e.acc   = cyc;
         e.first = (j == 0);
         e.err   = (a >= depth);
         e.last  = (j == l);
         e.dat   = (a < depth) ? tbl[a] : 4'h0;
         if (k == 0) q0.push_back(e); else q1.push_back(e);
         a = (a >= depth - 1) ? 0 : a + 1;
      end
   endtask

   // One clock cycle for dut k: inputs are already set; evaluate what the
   // coming edge will do, then move to the next falling edge.
   task automatic tick(input int k);
      beat_t e;
      acc_now = 1'b0;
      #1;
      if (rst[k]) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk($sformatf("d%0d_hold_vld", k), dat_vld[k], 1);
            chk($sformatf("d%0d_hold_dat", k), dat[k], h_dat);
            chk($sformatf("d%0d_hold_last", k), last[k], h_last);
            chk($sformatf("d%0d_hold_err", k), err[k], h_err);
         end
         if (dat_vld[k]) begin
            if (dat_rdy[k]) begin
               hold_pend = 1'b0;
               if (qsize(k) == 0) begin
                  chk($sformatf("d%0d_extra_beat", k), 1, 0);
               end else begin
                  if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                  chk($sformatf("d%0d_dat", k), dat[k], e.dat);
                  chk($sformatf("d%0d_last", k), last[k], e.last);
                  chk($sformatf("d%0d_err", k), err[k], e.err);
                  if (e.first && lat_on)
                     chk($sformatf("d%0d_latency", k), cyc - int'(e.acc), 1 + k);
               end
            end else begin
               hold_pend = 1'b1;
               h_dat = dat[k]; h_last = last[k]; h_err = err[k];
            end
         end else begin
            hold_pend = 1'b0;
         end
         if (req_vld[k] && req_rdy[k]) begin
            push_burst(k, int'(addr[k]), int'(len[k]));
            acc_now = 1'b1;
            acc_cyc = cyc;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic req(input int k, input int a, input int l);
      req_vld[k] = 1'b1; addr[k] = 3'(a); len[k] = 3'(l);
      for (int i = 0; i < 64 && !acc_now; i++) tick(k);
      if (!acc_now) chk($sformatf("d%0d_req_timeout", k), 0, 1);
      req_vld[k] = 1'b0;
      acc_now = 1'b0;
   endtask

   task automatic drain(input int k);
      req_vld[k] = 1'b0; dat_rdy[k] = 1'b1;
      for (int i = 0; i < 60 && qsize(k) != 0; i++) tick(k);
      tick(k); tick(k);
      chk($sformatf("d%0d_drain_left", k), qsize(k), 0);
      chk($sformatf("d%0d_busy_idle", k), busy[k], 0);
   endtask

   task automatic chk_zero(input int k, input string tag);
      chk({tag, "_vld"}, dat_vld[k], 0);
      chk({tag, "_dat"}, dat[k], 0);
      chk({tag, "_last"}, last[k], 0);
      chk({tag, "_err"}, err[k], 0);
      chk({tag, "_busy"}, busy[k], 0);
      chk({tag, "_rdy"}, req_rdy[k], 0);
   endtask

   task automatic do_reset(input int k);
      rst[k] = 1'b1; req_vld[k] = 1'b0; dat_rdy[k] = 1'b1;
      tick(k); tick(k);
      chk_zero(k, $sformatf("d%0d_rst", k));
      rst[k] = 1'b0;
      qclear(k); hold_pend = 1'b0;
      tick(k);
      chk($sformatf("d%0d_rdy_after_rst", k), req_rdy[k], 1);
   endtask

   task automatic random_phase(input int k, input int n);
      lat_on = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (!req_vld[k] && $urandom_range(0, 3) == 0) begin
            req_vld[k] = 1'b1;
            addr[k] = 3'($urandom_range(0, 7));
            len[k]  = 3'($urandom_range(0, 7));
         end
         dat_rdy[k] = ($urandom_range(0, 9) < 7);
         tick(k);
         if (acc_now) req_vld[k] = 1'b0;
      end
      drain(k);
   endtask

   initial begin
      int stalls, ta, tb;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; req_vld[k] = 1'b0; addr[k] = 3'd0; len[k] = 3'd0; dat_rdy[k] = 1'b1;
      end
      @(negedge clk);

      // ---------------- dut0: DEPTH=8, OUT_REG=0 ----------------
      do_reset(0);
      lat_on = 1'b1;
      req(0, 4, 0);
      chk("d0_rdy_after_single", req_rdy[0], 1);
      drain(0);
      req(0, 6, 3);
      drain(0);

      // backpressure on beat 2 for three cycles
      req(0, 0, 4);
      stalls = 0;
      for (int i = 0; i < 30 && qsize(0) != 0; i++) begin
         if (dat_vld[0] && qsize(0) == 4 && stalls < 3) begin
            dat_rdy[0] = 1'b0; stalls++;
         end else begin
            dat_rdy[0] = 1'b1;
         end
         tick(0);
      end
      chk("d0_stall_cycles", stalls, 3);
      drain(0);

      // back-to-back: second request held while the first burst runs
      req_vld[0] = 1'b1; addr[0] = 3'd0; len[0] = 3'd2;
      for (int i = 0; i < 20 && !acc_now; i++) tick(0);
      ta = acc_cyc;
      addr[0] = 3'd5; len[0] = 3'd1;
      tick(0);
      for (int i = 0; i < 20 && !acc_now; i++) tick(0);
      tb = acc_cyc;
      req_vld[0] = 1'b0;
      chk("d0_b2b_gap", tb - ta, 3);
      drain(0);

      // reset in the middle of a burst
      req(0, 0, 7);
      for (int i = 0; i < 20 && qsize(0) > 6; i++) tick(0);
      rst[0] = 1'b1;
      tick(0);
      chk_zero(0, "d0_midrst");
      rst[0] = 1'b0;
      qclear(0); hold_pend = 1'b0;
      tick(0);
      req(0, 3, 0);
      drain(0);

      random_phase(0, 400);

      // ---------------- dut1: DEPTH=5, OUT_REG=1 ----------------
      do_reset(1);
      lat_on = 1'b1;
      req(1, 6, 1);
      drain(1);
      req(1, 3, 3);
      drain(1);
      req(1, 0, 7);
      drain(1);
      random_phase(1, 400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
